// File: rtl/lfsr_step_scheduler.sv
// lfsr_step_scheduler: command-driven sequencer for the 64-bit LFSR datapath.
// Issues a one-cycle seed-load strobe and one-cycle step enables at a
// programmable division of i_clk, either continuously (RUN) or for a fixed
// number of steps (BURST), with STOP abort. Everything runs on i_clk; the LFSR
// consumes o_step as a clock enable.
//
// Ports:
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_cmd_valid/i_cmd command handshake; 00 LOAD, 01 RUN, 10 BURST, 11 STOP
//   i_cmd_div         step period in i_clk cycles (0 treated as 1)
//   i_cmd_len         BURST step count
//   o_cmd_ready       command accepted on i_cmd_valid && o_cmd_ready
//   o_seed_load       one-cycle seed-load strobe
//   o_step            one-cycle step enable
//   o_busy            high in RUN or BURST
//   o_done            one-cycle pulse at BURST end or STOP abort
//   o_cmd_err         one-cycle pulse when a non-STOP command arrives while busy
//   o_step_cnt        steps issued since the last accepted RUN/BURST (saturating)
module lfsr_step_scheduler #(
  parameter int unsigned CNT_W = 32,
  parameter int unsigned LEN_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_cmd_valid,
  input  logic [1:0]       i_cmd,
  input  logic [CNT_W-1:0] i_cmd_div,
  input  logic [LEN_W-1:0] i_cmd_len,
  output logic             o_cmd_ready,
  output logic             o_seed_load,
  output logic             o_step,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_cmd_err,
  output logic [CNT_W-1:0] o_step_cnt
);

  localparam logic [1:0] CMD_LOAD  = 2'b00;
  localparam logic [1:0] CMD_RUN   = 2'b01;
  localparam logic [1:0] CMD_BURST = 2'b10;
  localparam logic [1:0] CMD_STOP  = 2'b11;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_BURST = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] step_cnt_q, step_cnt_d;
  logic             step_q, step_d;
  logic             err_q, err_d;
  logic             ready_q, seed_q, busy_q, done_q;
  logic             accept;
  logic [CNT_W-1:0] div_eff;

  assign accept  = i_cmd_valid && ready_q;
  assign div_eff = (i_cmd_div == '0) ? CNT_W'(1) : i_cmd_div;

  // Next-state, divider and step bookkeeping
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    len_d      = len_q;
    step_cnt_d = step_cnt_q;
    step_d     = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (i_cmd)
            CMD_LOAD: state_d = S_LOAD;
            CMD_RUN: begin
              state_d    = S_RUN;
              div_d      = div_eff;
              cnt_d      = '0;
              step_cnt_d = '0;
            end
            CMD_BURST: begin
              div_d      = div_eff;
              len_d      = i_cmd_len;
              cnt_d      = '0;
              step_cnt_d = '0;
              state_d    = (i_cmd_len == '0) ? S_DONE : S_BURST;
            end
            default: state_d = S_IDLE;
          endcase
        end
      end
      S_RUN, S_BURST: begin
        if (accept && (i_cmd == CMD_STOP)) begin
          // Abort wins over a coincident terminal count: no step is issued
          state_d = S_DONE;
        end else begin
          err_d = accept;
          // The last burst step is on o_step now; finish without another step
          if ((state_q == S_BURST) && step_q && (step_cnt_q == CNT_W'(len_q))) begin
            state_d = S_DONE;
          end else if (cnt_q == (div_q - CNT_W'(1))) begin
            cnt_d  = '0;
            step_d = 1'b1;
            if (step_cnt_q != '1) begin
              step_cnt_d = step_cnt_q + CNT_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_LOAD, S_DONE: state_d = S_IDLE;
      default:        state_d = S_IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      div_q      <= CNT_W'(1);
      len_q      <= '0;
      step_cnt_q <= '0;
      step_q     <= 1'b0;
      err_q      <= 1'b0;
      ready_q    <= 1'b1;
      seed_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      len_q      <= len_d;
      step_cnt_q <= step_cnt_d;
      step_q     <= step_d;
      err_q      <= err_d;
      ready_q    <= (state_d != S_LOAD) && (state_d != S_DONE);
      seed_q     <= (state_d == S_LOAD);
      busy_q     <= (state_d == S_RUN) || (state_d == S_BURST);
      done_q     <= (state_d == S_DONE);
    end
  end

  assign o_cmd_ready = ready_q;
  assign o_seed_load = seed_q;
  assign o_step      = step_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_cmd_err   = err_q;
  assign o_step_cnt  = step_cnt_q;

endmodule
